// File: rtl/ofdm_frame_sched.sv
// ofdm_frame_sched
//   Packs mapped 16QAM symbols into Hermitian-symmetric NFFT-point frames for
//   an IFFT core. Two half-frame banks ping-pong: one fills from the mapper
//   while the other streams out, so the IFFT output is real-valued.
//
//   Frame order (H = NFFT/2, m = NFFT-k):
//     k = 0        -> (I0, 0)
//     1 <= k < H   -> (Ik, Qk)
//     k = H        -> (Q0, 0)
//     k > H        -> (Im, -Qm)   negation saturates
//
//   Optional build macro HERM_DC_NULL_EN: only H-1 symbols per frame are
//   taken (stored as X1..X(H-1)) and bins k=0 and k=H carry (0,0).
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   sym_valid/ready   mapper handshake; sym_i/sym_q carry the symbol
//   sink_valid/ready  FFT sink handshake; sink_sop/eop mark k=0 / k=NFFT-1
//   sink_real/imag    output sample
//   frame_done        high during the cycle the eop transfer happens
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A source holds its payload stable while valid && !ready, and
// ready is never used when valid is low.
module ofdm_frame_sched #(
    parameter int DW   = 8,
    parameter int NFFT = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sym_valid,
    output logic          sym_ready,
    input  logic [DW-1:0] sym_i,
    input  logic [DW-1:0] sym_q,
    input  logic          sink_ready,
    output logic          sink_valid,
    output logic          sink_sop,
    output logic          sink_eop,
    output logic [DW-1:0] sink_real,
    output logic [DW-1:0] sink_imag,
    output logic          frame_done
);
    localparam int H  = NFFT / 2;
    localparam int AW = $clog2(H);
    localparam int KW = $clog2(NFFT);
`ifdef HERM_DC_NULL_EN
    localparam logic [AW-1:0] WR_FIRST = AW'(1);
`else
    localparam logic [AW-1:0] WR_FIRST = AW'(0);
`endif
    localparam logic [AW-1:0] WR_LAST  = AW'(H - 1);
    localparam logic [DW-1:0] MIN_VAL  = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] MAX_VAL  = {1'b0, {(DW-1){1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM} state_t;

    logic [DW-1:0] mem_i [2][H];
    logic [DW-1:0] mem_q [2][H];

    // ---------------- write side ----------------
    logic [1:0]    full;
    logic          wr_bank;
    logic [AW-1:0] wr_idx;
    logic          run;      // low only in the cycle after reset
    logic          accept;
    logic          fill;
    logic          free;
    logic          rd_bank;

    assign sym_ready = run && !full[wr_bank];
    assign accept    = sym_valid && sym_ready;
    assign fill      = accept && (wr_idx == WR_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            wr_idx  <= WR_FIRST;
            run     <= 1'b0;
        end else begin
            run <= 1'b1;
            if (accept) begin
                if (fill) begin
                    wr_idx  <= WR_FIRST;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
            // The filled bank and the freed bank are never the same bank,
            // so a same-cycle fill and free both land.
            if (fill) full[wr_bank] <= 1'b1;
            if (free) full[rd_bank] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_i[wr_bank][wr_idx] <= sym_i;
            mem_q[wr_bank][wr_idx] <= sym_q;
        end
    end

    // ---------------- sample lookup ----------------
    state_t        state, state_n;
    logic [KW-1:0] k, k_n;
    logic [KW-1:0] smp_k;
    logic [KW-1:0] mirror;
    logic [AW-1:0] addr;
    logic [DW-1:0] rd_i, rd_q;
    logic [DW-1:0] smp_re, smp_im;

    // LOAD fetches k=0; STREAM prefetches the sample after the current one.
    assign smp_k  = (state == S_STREAM) ? k + 1'b1 : '0;
    assign mirror = -smp_k;
    // Upper half mirrors to NFFT-k; k=H maps to index 0 through truncation.
    assign addr   = smp_k[KW-1] ? mirror[AW-1:0] : smp_k[AW-1:0];
    assign rd_i   = mem_i[rd_bank][addr];
    assign rd_q   = mem_q[rd_bank][addr];

    always_comb begin
        smp_re = rd_i;
        smp_im = rd_q;
        if (smp_k == '0) begin
`ifdef HERM_DC_NULL_EN
            smp_re = '0;
`else
            smp_re = rd_i;
`endif
            smp_im = '0;
        end else if (smp_k == KW'(H)) begin
`ifdef HERM_DC_NULL_EN
            smp_re = '0;
`else
            smp_re = rd_q;
`endif
            smp_im = '0;
        end else if (smp_k[KW-1]) begin
            smp_im = (rd_q == MIN_VAL) ? MAX_VAL : -rd_q;
        end
    end

    // ---------------- read FSM ----------------
    logic          rd_bank_n;
    logic          valid_n, sop_n, eop_n;
    logic [DW-1:0] real_n, imag_n;
    logic          other_full;

    // Count a fill landing this very cycle so back-to-back frames keep one gap.
    assign other_full = full[~rd_bank] || (fill && (wr_bank != rd_bank));

    always_comb begin
        state_n   = state;
        k_n       = k;
        rd_bank_n = rd_bank;
        valid_n   = sink_valid;
        sop_n     = sink_sop;
        eop_n     = sink_eop;
        real_n    = sink_real;
        imag_n    = sink_imag;
        free      = 1'b0;
        case (state)
            S_IDLE: begin
                if (full[rd_bank]) state_n = S_LOAD;
            end
            S_LOAD: begin
                state_n = S_STREAM;
                k_n     = '0;
                valid_n = 1'b1;
                sop_n   = 1'b1;
                eop_n   = 1'b0;
                real_n  = smp_re;
                imag_n  = smp_im;
            end
            S_STREAM: begin
                if (sink_ready) begin
                    if (k == KW'(NFFT - 1)) begin
                        free      = 1'b1;
                        rd_bank_n = ~rd_bank;
                        state_n   = other_full ? S_LOAD : S_IDLE;
                        valid_n   = 1'b0;
                        sop_n     = 1'b0;
                        eop_n     = 1'b0;
                        real_n    = '0;
                        imag_n    = '0;
                    end else begin
                        k_n    = k + 1'b1;
                        sop_n  = 1'b0;
                        eop_n  = (k == KW'(NFFT - 2));
                        real_n = smp_re;
                        imag_n = smp_im;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            k          <= '0;
            rd_bank    <= 1'b0;
            sink_valid <= 1'b0;
            sink_sop   <= 1'b0;
            sink_eop   <= 1'b0;
            sink_real  <= '0;
            sink_imag  <= '0;
        end else begin
            state      <= state_n;
            k          <= k_n;
            rd_bank    <= rd_bank_n;
            sink_valid <= valid_n;
            sink_sop   <= sop_n;
            sink_eop   <= eop_n;
            sink_real  <= real_n;
            sink_imag  <= imag_n;
        end
    end

    assign frame_done = sink_valid && sink_ready && sink_eop;

endmodule

// File: tb/tb_ofdm_frame_sched.sv
module tb_ofdm_frame_sched;
  localparam int DW   = 8;
  localparam int NFFT = 128;
  localparam int H    = NFFT / 2;
`ifdef HERM_DC_NULL_EN
  localparam int SPF  = H - 1;
`else
  localparam int SPF  = H;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          sym_valid = 1'b0;
  logic          sym_ready;
  logic [DW-1:0] sym_i = '0;
  logic [DW-1:0] sym_q = '0;
  logic          sink_ready = 1'b0;
  logic          sink_valid, sink_sop, sink_eop, frame_done;
  logic [DW-1:0] sink_real, sink_imag;

  ofdm_frame_sched #(.DW(DW), .NFFT(NFFT)) dut (
    .clk(clk), .reset(reset),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_i(sym_i), .sym_q(sym_q),
    .sink_ready(sink_ready), .sink_valid(sink_valid), .sink_sop(sink_sop),
    .sink_eop(sink_eop), .sink_real(sink_real), .sink_imag(sink_imag),
    .frame_done(frame_done)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int tab_i [0:199];
  int tab_q [0:199];
  int got_re[$], got_im[$], sop_idx[$], eop_idx[$], sop_cyc[$], eop_cyc[$];
  int fd_cnt, acc_cyc;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int neg_sat(input int q);
    return (q == -(1 << (DW-1))) ? (1 << (DW-1)) - 1 : -q;
  endfunction

  // Frame model straight from the bin map.
  function automatic void exp_smp(input int base, input int k, output int re, output int im);
    int m;
    m = NFFT - k;
`ifdef HERM_DC_NULL_EN
    if (k == 0 || k == H) begin re = 0; im = 0; end
    else if (k < H) begin re = tab_i[base+k-1]; im = tab_q[base+k-1]; end
    else begin re = tab_i[base+m-1]; im = neg_sat(tab_q[base+m-1]); end
`else
    if (k == 0) begin re = tab_i[base]; im = 0; end
    else if (k == H) begin re = tab_q[base]; im = 0; end
    else if (k < H) begin re = tab_i[base+k]; im = tab_q[base+k]; end
    else begin re = tab_i[base+m]; im = neg_sat(tab_q[base+m]); end
`endif
  endfunction

  function automatic int qget(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -9999;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; sym_valid = 1'b0; sink_ready = 1'b0;
    @(negedge clk);
    chk("rst_sym_ready", int'(sym_ready), 0);
    chk("rst_valid", int'(sink_valid), 0);
    chk("rst_sop", int'(sink_sop), 0);
    chk("rst_eop", int'(sink_eop), 0);
    chk("rst_real", int'(sink_real), 0);
    chk("rst_imag", int'(sink_imag), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_sym_ready_after", int'(sym_ready), 1);
  endtask

  // mode 0: sink_ready=1; mode 1: toggles; mode 2: 0 until cycle 'stall'.
  // abort_k >= 0 asserts reset while output k=abort_k is presented.
  task automatic run(input int n_sym, input int mode, input int stall,
                     input int n_frames, input int abort_k);
    int sent, cyc, nfr, h_re, h_im, h_sop, h_eop;
    bit hold;
    sent = 0; cyc = 0; nfr = 0; hold = 0; fd_cnt = 0; acc_cyc = -1;
    h_re = 0; h_im = 0; h_sop = 0; h_eop = 0;
    got_re.delete(); got_im.delete(); sop_idx.delete(); eop_idx.delete();
    sop_cyc.delete(); eop_cyc.delete();
    while (nfr < n_frames && cyc < 3000) begin
      @(negedge clk);
      if (hold) begin
        chk("hold_re", int'($signed(sink_real)), h_re);
        chk("hold_im", int'($signed(sink_imag)), h_im);
        chk("hold_sop", int'(sink_sop), h_sop);
        chk("hold_eop", int'(sink_eop), h_eop);
      end
      if (abort_k >= 0 && sink_valid && got_re.size() == abort_k) begin
        reset = 1'b1; sym_valid = 1'b0; sink_ready = 1'b0;
        return;
      end
      if (mode == 2 && cyc == stall - 1) begin
        chk("stall_sent", sent, 2 * SPF);
        chk("stall_sym_ready", int'(sym_ready), 0);
      end
      case (mode)
        0:       sink_ready = 1'b1;
        1:       sink_ready = cyc[0];
        default: sink_ready = (cyc >= stall);
      endcase
      sym_valid = (sent < n_sym);
      sym_i = DW'(sym_valid ? tab_i[sent] : 0);
      sym_q = DW'(sym_valid ? tab_q[sent] : 0);
      if (sym_valid && sym_ready) begin
        sent++;
        if (sent == SPF) acc_cyc = cyc;
      end
      if (sink_valid && sink_ready) begin
        if (sink_sop) begin sop_idx.push_back(got_re.size()); sop_cyc.push_back(cyc); end
        if (sink_eop) begin eop_idx.push_back(got_re.size()); eop_cyc.push_back(cyc); nfr++; end
        got_re.push_back(int'($signed(sink_real)));
        got_im.push_back(int'($signed(sink_imag)));
      end
      hold  = sink_valid && !sink_ready;
      h_re  = int'($signed(sink_real)); h_im = int'($signed(sink_imag));
      h_sop = int'(sink_sop); h_eop = int'(sink_eop);
      #1;
      if (frame_done) fd_cnt++;
      cyc++;
    end
    if (nfr < n_frames) chk("timeout_frames", nfr, n_frames);
    @(negedge clk);
    sym_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int f, input int base);
    int re, im;
    for (int k = 0; k < NFFT; k++) begin
      exp_smp(base, k, re, im);
      chk($sformatf("%s_k%0d_re", tag, k), qget(got_re, f*NFFT + k), re);
      chk($sformatf("%s_k%0d_im", tag, k), qget(got_im, f*NFFT + k), im);
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
`ifdef HERM_DC_NULL_EN
    do_reset();
    for (int j = 0; j < 200; j++) begin tab_i[j] = (j % 63) + 1; tab_q[j] = (j % 63) + 1; end
    run(SPF, 0, 0, 1, -1);
    chk("dc_count", got_re.size(), NFFT);
    chk("dc_k0_re", qget(got_re, 0), 0);
    chk("dc_k0_im", qget(got_im, 0), 0);
    chk("dc_k64_re", qget(got_re, 64), 0);
    chk("dc_k64_im", qget(got_im, 64), 0);
    chk("dc_k127_re", qget(got_re, 127), 1);
    chk("dc_k127_im", qget(got_im, 127), -1);
    chk("dc_latency", qget(sop_cyc, 0) - acc_cyc, 3);
    chk("dc_frame_done", fd_cnt, 1);
    check_frame("dc", 0, 0);
`else
    // Reset state.
    do_reset();

    // Single frame: I=k, Q=-k.
    for (int j = 0; j < 200; j++) begin tab_i[j] = j % 64; tab_q[j] = -(j % 64); end
    run(64, 0, 0, 1, -1);
    chk("single_count", got_re.size(), 128);
    chk("single_sop_idx", qget(sop_idx, 0), 0);
    chk("single_eop_idx", qget(eop_idx, 0), 127);
    chk("single_k0_re", qget(got_re, 0), 0);
    chk("single_k0_im", qget(got_im, 0), 0);
    chk("single_k5_re", qget(got_re, 5), 5);
    chk("single_k5_im", qget(got_im, 5), -5);
    chk("single_k64_re", qget(got_re, 64), 0);
    chk("single_k64_im", qget(got_im, 64), 0);
    chk("single_k123_re", qget(got_re, 123), 5);
    chk("single_k123_im", qget(got_im, 123), 5);
    chk("single_k127_re", qget(got_re, 127), 1);
    chk("single_k127_im", qget(got_im, 127), 1);
    chk("single_latency", qget(sop_cyc, 0) - acc_cyc, 3);
    chk("single_frame_done", fd_cnt, 1);
    check_frame("single", 0, 0);

    // Backpressure: sink_ready toggles every cycle.
    do_reset();
    run(64, 1, 0, 1, -1);
    chk("bp_count", got_re.size(), 128);
    chk("bp_eop_idx", qget(eop_idx, 0), 127);
    chk("bp_frame_done", fd_cnt, 1);
    check_frame("bp", 0, 0);

    // Ping-pong: 130 symbols against a stalled sink.
    do_reset();
    for (int j = 0; j < 200; j++) begin
      tab_i[j] = (j * 7) % 200 - 100;
      tab_q[j] = 90 - (j * 3) % 180;
    end
    run(130, 2, 300, 2, -1);
    chk("pp_count", got_re.size(), 256);
    chk("pp_sop1_idx", qget(sop_idx, 1), 128);
    chk("pp_eop1_idx", qget(eop_idx, 1), 255);
    chk("pp_gap", qget(sop_cyc, 1) - qget(eop_cyc, 0), 2);
    chk("pp_frame_done", fd_cnt, 2);
    check_frame("pp_f0", 0, 0);
    check_frame("pp_f1", 1, 64);

    // Saturation: X3 = (-128, -128).
    do_reset();
    for (int j = 0; j < 200; j++) begin tab_i[j] = j % 64; tab_q[j] = -(j % 64); end
    tab_i[3] = -128; tab_q[3] = -128;
    run(64, 0, 0, 1, -1);
    chk("sat_k3_re", qget(got_re, 3), -128);
    chk("sat_k3_im", qget(got_im, 3), -128);
    chk("sat_k125_re", qget(got_re, 125), -128);
    chk("sat_k125_im", qget(got_im, 125), 127);
    check_frame("sat", 0, 0);

    // Mid-frame reset at output k=40, then a clean reload.
    do_reset();
    tab_i[3] = 3; tab_q[3] = -3;
    run(64, 0, 0, 1, 40);
    chk("abort_got", got_re.size(), 40);
    @(negedge clk);
    chk("abort_valid", int'(sink_valid), 0);
    chk("abort_eop", int'(sink_eop), 0);
    chk("abort_frame_done", int'(frame_done), 0);
    chk("abort_eops", eop_idx.size(), 0);
    reset = 1'b0;
    @(negedge clk);
    run(64, 0, 0, 1, -1);
    chk("reload_count", got_re.size(), 128);
    chk("reload_sop_idx", qget(sop_idx, 0), 0);
    chk("reload_eop_idx", qget(eop_idx, 0), 127);
    check_frame("reload", 0, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
